// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO result register unit
package hilo_pkg;

   // Architectural HI/LO register width; the product is twice this
   localparam int HILO_W = 32;
   localparam int PROD_W = 2 * HILO_W;

   // Read select encodings (2'b11 is decoded as no read)
   localparam logic [1:0] RD_NONE = 2'b00;
   localparam logic [1:0] RD_HI   = 2'b01;
   localparam logic [1:0] RD_LO   = 2'b10;

   // Multiply tracking state
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO registers fed by the pipelined multiplier; optional read forwarding under HILO_FWD_EN
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int MULT_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              mult_start,
   input  logic [PROD_W-1:0] product,
   input  logic              wr_hi,
   input  logic              wr_lo,
   input  logic [HILO_W-1:0] wr_data,
   input  logic [1:0]        rd_sel,
   output logic [HILO_W-1:0] rd_data,
   output logic              stall,
   output logic [HILO_W-1:0] hi,
   output logic [HILO_W-1:0] lo,
   output logic              busy
);

   localparam int              CNT_W    = $clog2(MULT_LATENCY) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [HILO_W-1:0]   hi_q, hi_d;
   logic [HILO_W-1:0]   lo_q, lo_d;

   logic                rd_req;
   logic                wr_req;
   logic                last_wait;
   logic                rd_blocked;
   logic                fwd_sel;

   // Hazard decode: what the current request wants and whether the product lands this edge
   always_comb begin
      rd_req    = (rd_sel == RD_HI) || (rd_sel == RD_LO);
      wr_req    = wr_hi || wr_lo;
      last_wait = (state_q == WAIT) && (cnt_q == '0);
`ifdef HILO_FWD_EN
      // The product on the bus is final in the capture cycle, so a read can take it directly
      rd_blocked = rd_req && !last_wait;
      fwd_sel    = last_wait;
`else
      rd_blocked = rd_req;
      fwd_sel    = 1'b0;
`endif
      stall = (state_q == WAIT) && (rd_blocked || wr_req || mult_start);
   end

   // Read mux; returns the pre-edge register value even when a write is pending
   always_comb begin
      rd_data = '0;
      case (rd_sel)
         RD_HI:   rd_data = fwd_sel ? product[PROD_W-1:HILO_W] : hi_q;
         RD_LO:   rd_data = fwd_sel ? product[HILO_W-1:0]      : lo_q;
         default: rd_data = '0;
      endcase
   end

   // Next-state: track the in-flight multiply, capture the product, apply IDLE writes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               // Writes land first; a multiply issued alongside overwrites both on capture
               if (wr_hi) hi_d = wr_data;
               if (wr_lo) lo_d = wr_data;
               if (mult_start) begin
                  cnt_d   = CNT_LOAD;
                  state_d = WAIT;
               end
            end
            WAIT: begin
               // Writes and new multiplies are stalled here and never reach the registers
               if (cnt_q == '0) begin
                  hi_d    = product[PROD_W-1:HILO_W];
                  lo_d    = product[HILO_W-1:0];
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers; reset drops any pending product
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Architectural outputs
   always_comb begin
      hi   = hi_q;
      lo   = lo_q;
      busy = (state_q == WAIT);
   end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit at latencies 1 and 3
module tb_hilo_unit;

`ifdef HILO_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int STALL_N = FWD ? 2 : 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        mult_start;
   logic [63:0] product;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wr_data;
   logic [1:0]  rd_sel;

   logic [31:0] rd_o   [2];
   logic [31:0] hi_o   [2];
   logic [31:0] lo_o   [2];
   logic        stall_o[2];
   logic        busy_o [2];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: edges remaining until capture (0 = idle) and architectural values
   int          m_left[2];
   logic [31:0] m_hi[2];
   logic [31:0] m_lo[2];

   always #5 clk = ~clk;

   hilo_unit #(.MULT_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .en(en), .mult_start(mult_start), .product(product),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .rd_sel(rd_sel),
      .rd_data(rd_o[0]), .stall(stall_o[0]), .hi(hi_o[0]), .lo(lo_o[0]), .busy(busy_o[0])
   );

   hilo_unit #(.MULT_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .en(en), .mult_start(mult_start), .product(product),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .rd_sel(rd_sel),
      .rd_data(rd_o[1]), .stall(stall_o[1]), .hi(hi_o[1]), .lo(lo_o[1]), .busy(busy_o[1])
   );

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic exp_stall(input int i);
      bit rd;
      bit fwd_ok;
      rd     = (rd_sel == 2'b01) || (rd_sel == 2'b10);
      fwd_ok = FWD && (m_left[i] == 1);
      if (m_left[i] == 0) return 1'b0;
      return (rd && !fwd_ok) || wr_hi || wr_lo || mult_start;
   endfunction

   function automatic logic [31:0] exp_rd(input int i);
      bit fw;
      fw = FWD && (m_left[i] == 1);
      case (rd_sel)
         2'b01:   return fw ? product[63:32] : m_hi[i];
         2'b10:   return fw ? product[31:0]  : m_lo[i];
         default: return 32'h0;
      endcase
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         m_left[i] = 0;
         m_hi[i]   = 32'h0;
         m_lo[i]   = 32'h0;
      end
   endtask

   // Advance one clock edge and apply the architectural rules to the reference
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!reset && en) begin
            if (m_left[i] > 0) begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  m_hi[i] = product[63:32];
                  m_lo[i] = product[31:0];
               end
            end else begin
               if (wr_hi) m_hi[i] = wr_data;
               if (wr_lo) m_lo[i] = wr_data;
               if (mult_start) m_left[i] = lat(i);
            end
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b1; mult_start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; rd_sel = 2'b00;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1; rd_sel = 2'b01; product = {$urandom, $urandom}; wr_data = $urandom;
      clear_model();
      tick(); tick();
      n_cmp++; if (hi_o[0] !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h exp 0", hi_o[0]); end
      n_cmp++; if (lo_o[0] !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h exp 0", lo_o[0]); end
      n_cmp++; if (busy_o[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy_o[0]); end
      n_cmp++; if (stall_o[0] !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall_o[0]); end
      n_cmp++; if (rd_o[0] !== 32'h0) begin n_bad++; $display("FAIL reset_rd got %h exp 0", rd_o[0]); end
      n_cmp++; if (hi_o[1] !== 32'h0) begin n_bad++; $display("FAIL reset_hi3 got %h exp 0", hi_o[1]); end
      reset = 1'b0; rd_sel = 2'b00;
      tick();
   endtask

   task automatic test_negative_product();
      idle_inputs();
      product = 64'hFFFFFFFF_FFFFFFEB; mult_start = 1'b1;
      #1;
      n_cmp++; if (stall_o[0] !== 1'b0) begin n_bad++; $display("FAIL neg_idle_stall got %b exp 0", stall_o[0]); end
      tick();
      mult_start = 1'b0;
      n_cmp++; if (busy_o[0] !== 1'b1) begin n_bad++; $display("FAIL neg_busy got %b exp 1", busy_o[0]); end
      n_cmp++; if (hi_o[0] !== 32'h0) begin n_bad++; $display("FAIL neg_hi_early got %h exp 0", hi_o[0]); end
      tick();
      n_cmp++; if (hi_o[0] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL neg_hi got %h exp ffffffff", hi_o[0]); end
      n_cmp++; if (lo_o[0] !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL neg_lo got %h exp ffffffeb", lo_o[0]); end
      n_cmp++; if (busy_o[0] !== 1'b0) begin n_bad++; $display("FAIL neg_busy_drop got %b exp 0", busy_o[0]); end
      n_cmp++; if (busy_o[1] !== 1'b1) begin n_bad++; $display("FAIL neg_busy3 got %b exp 1", busy_o[1]); end
      tick(); tick();
      n_cmp++; if (lo_o[1] !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL neg_lo3 got %h exp ffffffeb", lo_o[1]); end
      n_cmp++; if (busy_o[1] !== 1'b0) begin n_bad++; $display("FAIL neg_busy3_drop got %b exp 0", busy_o[1]); end
   endtask

   task automatic test_read_during_wait();
      logic [31:0] lo_old;
      idle_inputs();
      lo_old = m_lo[1];
      product = 64'hFFFFFFFF_FFFFFF06; mult_start = 1'b1;
      tick();
      mult_start = 1'b0; rd_sel = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (stall_o[1] !== (c < STALL_N)) begin
            n_bad++; $display("FAIL rdwait_stall c=%0d got %b exp %b", c, stall_o[1], (c < STALL_N));
         end
         if (c == 2) begin
            n_cmp++;
            if (rd_o[1] !== (FWD ? 32'hFFFFFF06 : lo_old)) begin
               n_bad++; $display("FAIL rdwait_fwd got %h exp %h", rd_o[1], (FWD ? 32'hFFFFFF06 : lo_old));
            end
         end
         tick();
      end
      #1;
      n_cmp++; if (stall_o[1] !== 1'b0) begin n_bad++; $display("FAIL rdwait_stall_end got %b exp 0", stall_o[1]); end
      n_cmp++; if (rd_o[1] !== 32'hFFFFFF06) begin n_bad++; $display("FAIL rdwait_rd got %h exp ffffff06", rd_o[1]); end
      rd_sel = 2'b00;
   endtask

   task automatic test_write_ordering();
      logic [31:0] d;
      idle_inputs();
      wr_hi = 1'b1; wr_data = 32'h12345678; mult_start = 1'b1; product = 64'd10;
      tick();
      wr_hi = 1'b0; mult_start = 1'b0;
      n_cmp++; if (hi_o[0] !== 32'h12345678) begin n_bad++; $display("FAIL word_hi1 got %h exp 12345678", hi_o[0]); end
      n_cmp++; if (hi_o[1] !== 32'h12345678) begin n_bad++; $display("FAIL word_hi3 got %h exp 12345678", hi_o[1]); end
      tick();
      n_cmp++; if (hi_o[0] !== 32'h0) begin n_bad++; $display("FAIL word_cap_hi got %h exp 0", hi_o[0]); end
      n_cmp++; if (lo_o[0] !== 32'hA) begin n_bad++; $display("FAIL word_cap_lo got %h exp a", lo_o[0]); end
      tick(); tick();
      n_cmp++; if (hi_o[1] !== 32'h0) begin n_bad++; $display("FAIL word_cap_hi3 got %h exp 0", hi_o[1]); end
      n_cmp++; if (lo_o[1] !== 32'hA) begin n_bad++; $display("FAIL word_cap_lo3 got %h exp a", lo_o[1]); end
      d = $urandom;
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = d; rd_sel = 2'b01;
      #1;
      n_cmp++; if (rd_o[0] !== 32'h0) begin n_bad++; $display("FAIL rd_old got %h exp 0", rd_o[0]); end
      tick();
      idle_inputs();
      n_cmp++; if (hi_o[0] !== d) begin n_bad++; $display("FAIL both_hi got %h exp %h", hi_o[0], d); end
      n_cmp++; if (lo_o[0] !== d) begin n_bad++; $display("FAIL both_lo got %h exp %h", lo_o[0], d); end
   endtask

   task automatic test_en_freeze();
      logic [63:0] p;
      logic [31:0] old_hi;
      idle_inputs();
      old_hi = m_hi[1];
      p = {$urandom, $urandom};
      product = p; mult_start = 1'b1;
      tick();
      mult_start = 1'b0;
      tick();
      en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++; if (busy_o[1] !== 1'b1) begin n_bad++; $display("FAIL freeze_busy c=%0d got %b exp 1", c, busy_o[1]); end
         n_cmp++; if (hi_o[1] !== old_hi) begin n_bad++; $display("FAIL freeze_hi c=%0d got %h exp %h", c, hi_o[1], old_hi); end
      end
      en = 1'b1;
      tick();
      n_cmp++; if (busy_o[1] !== 1'b1) begin n_bad++; $display("FAIL freeze_busy_late got %b exp 1", busy_o[1]); end
      n_cmp++; if (hi_o[1] !== old_hi) begin n_bad++; $display("FAIL freeze_early_cap got %h exp %h", hi_o[1], old_hi); end
      tick();
      n_cmp++; if (hi_o[1] !== p[63:32]) begin n_bad++; $display("FAIL freeze_cap_hi got %h exp %h", hi_o[1], p[63:32]); end
      n_cmp++; if (lo_o[1] !== p[31:0]) begin n_bad++; $display("FAIL freeze_cap_lo got %h exp %h", lo_o[1], p[31:0]); end
      n_cmp++; if (busy_o[1] !== 1'b0) begin n_bad++; $display("FAIL freeze_busy_end got %b exp 0", busy_o[1]); end
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      wr_hi = 1'b1; wr_data = 32'd5;
      tick();
      wr_hi = 1'b0;
      n_cmp++; if (hi_o[1] !== 32'd5) begin n_bad++; $display("FAIL rmw_hi5 got %h exp 5", hi_o[1]); end
      product = {$urandom | 32'h1, $urandom | 32'h1}; mult_start = 1'b1;
      tick();
      mult_start = 1'b0;
      n_cmp++; if (busy_o[1] !== 1'b1) begin n_bad++; $display("FAIL rmw_busy got %b exp 1", busy_o[1]); end
      #1;
      reset = 1'b1;
      clear_model();
      #1;
      n_cmp++; if (busy_o[1] !== 1'b0) begin n_bad++; $display("FAIL rmw_async_busy got %b exp 0", busy_o[1]); end
      n_cmp++; if (hi_o[1] !== 32'h0) begin n_bad++; $display("FAIL rmw_async_hi got %h exp 0", hi_o[1]); end
      n_cmp++; if (busy_o[0] !== 1'b0) begin n_bad++; $display("FAIL rmw_async_busy1 got %b exp 0", busy_o[0]); end
      tick();
      reset = 1'b0;
      tick(); tick(); tick();
      n_cmp++; if (hi_o[1] !== 32'h0) begin n_bad++; $display("FAIL rmw_no_cap_hi got %h exp 0", hi_o[1]); end
      n_cmp++; if (lo_o[1] !== 32'h0) begin n_bad++; $display("FAIL rmw_no_cap_lo got %h exp 0", lo_o[1]); end
      n_cmp++; if (busy_o[1] !== 1'b0) begin n_bad++; $display("FAIL rmw_idle got %b exp 0", busy_o[1]); end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      for (int c = 0; c < 10; c++) begin
         mult_start = 1'b1; product = {$urandom, $urandom};
         #1;
         n_cmp++; if (busy_o[0] !== (m_left[0] > 0)) begin n_bad++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy_o[0], (m_left[0] > 0)); end
         n_cmp++; if (stall_o[0] !== exp_stall(0)) begin n_bad++; $display("FAIL b2b_stall c=%0d got %b exp %b", c, stall_o[0], exp_stall(0)); end
         n_cmp++; if (hi_o[0] !== m_hi[0]) begin n_bad++; $display("FAIL b2b_hi c=%0d got %h exp %h", c, hi_o[0], m_hi[0]); end
         n_cmp++; if (lo_o[1] !== m_lo[1]) begin n_bad++; $display("FAIL b2b_lo3 c=%0d got %h exp %h", c, lo_o[1], m_lo[1]); end
         tick();
      end
      idle_inputs();
      repeat (4) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         en         = ($urandom_range(0, 9) != 0);
         mult_start = ($urandom_range(0, 3) == 0);
         wr_hi      = ($urandom_range(0, 5) == 0);
         wr_lo      = ($urandom_range(0, 5) == 0);
         wr_data    = $urandom;
         rd_sel     = 2'($urandom_range(0, 3));
         product    = {$urandom, $urandom};
         #1;
         for (int i = 0; i < 2; i++) begin
            n_cmp++; if (stall_o[i] !== exp_stall(i)) begin n_bad++; $display("FAIL rnd_stall d%0d c=%0d got %b exp %b", i, c, stall_o[i], exp_stall(i)); end
            n_cmp++; if (rd_o[i] !== exp_rd(i)) begin n_bad++; $display("FAIL rnd_rd d%0d c=%0d got %h exp %h", i, c, rd_o[i], exp_rd(i)); end
            n_cmp++; if (busy_o[i] !== (m_left[i] > 0)) begin n_bad++; $display("FAIL rnd_busy d%0d c=%0d got %b exp %b", i, c, busy_o[i], (m_left[i] > 0)); end
            n_cmp++; if (hi_o[i] !== m_hi[i]) begin n_bad++; $display("FAIL rnd_hi d%0d c=%0d got %h exp %h", i, c, hi_o[i], m_hi[i]); end
            n_cmp++; if (lo_o[i] !== m_lo[i]) begin n_bad++; $display("FAIL rnd_lo d%0d c=%0d got %h exp %h", i, c, lo_o[i], m_lo[i]); end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; mult_start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      wr_data = 32'h0; rd_sel = 2'b00; product = 64'h0;
      clear_model();
      test_reset();
      test_negative_product();
      test_read_during_wait();
      test_write_ordering();
      test_en_freeze();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
